// File: rtl/fsm_8.sv
// fsm_8: Moore serial sequence detector for the fixed pattern 1-1-1-0.
// A run of three or more 1s followed by a 0 produces one match, and matches
// may overlap: the 1 that follows a match can start the next one.
//
// Ports:
//   clk      - system clock, all state changes on the rising edge
//   reset    - asynchronous active-low reset (0 = reset asserted)
//   din      - serial data bit, sampled on the rising edge of clk
//   detected - one-cycle registered strobe while the match state is held
module fsm_8 (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic detected
);

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    S0 = 3'd0,  // idle, no useful prefix
    S1 = 3'd1,  // "1" seen
    S2 = 3'd2,  // "11" seen
    S3 = 3'd3,  // "111" or a longer run of 1s seen
    S4 = 3'd4   // "1110" matched
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   detected_q;
  logic   detected_d;

  // Next-state logic; encodings 5-7 fall to the default and recover to S0.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = din ? S1 : S0;
      S1:      state_d = din ? S2 : S0;
      S2:      state_d = din ? S3 : S0;
      S3:      state_d = din ? S3 : S4;
      S4:      state_d = din ? S1 : S0;
      default: state_d = S0;
    endcase
  end

  // The strobe is registered alongside the state, so it is high exactly
  // while state_q == S4 and has no combinational path from din.
  always_comb begin
    detected_d = 1'b0;
    if (state_d == S4) begin
      detected_d = 1'b1;
    end
  end

  // State and output registers. An asserted reset clears both at once,
  // discarding any partial progress through the pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S0;
      detected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      detected_q <= detected_d;
    end
  end

  assign detected = detected_q;

endmodule

// File: tb/tb_fsm_8.sv
// tb_fsm_8: scoreboard bench for fsm_8. For every clock edge the driver
// pushes the expected value of detected; a separate monitor pops and compares
// one entry just after each rising edge. The expected value comes from the
// history of bits sampled since the last reset: a match is signalled when
// the four most recent samples are 1,1,1,0.
module tb_fsm_8;

  logic clk;
  logic reset;
  logic din;
  logic detected;

  int n_cmp;
  int n_err;

  bit exp_q[$];   // expected detected after each rising edge
  bit hist[$];    // bits sampled since the last reset, oldest first

  fsm_8 dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .detected (detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one rising edge with the given reset level and din.
  function automatic bit model_edge(input bit rst_n, input bit d);
    int n;
    if (!rst_n) begin
      hist.delete();
      return 1'b0;
    end
    hist.push_back(d);
    n = hist.size();
    if (n < 4) return 1'b0;
    return hist[n-4] && hist[n-3] && hist[n-2] && !hist[n-1];
  endfunction

  // Drive one bit at the falling edge and record what the next rising edge
  // should produce.
  task automatic step(input bit rst_n, input bit d);
    @(negedge clk);
    reset = rst_n;
    din   = d;
    exp_q.push_back(model_edge(rst_n, d));
  endtask

  task automatic drive_seq(input bit bits[$]);
    foreach (bits[i]) step(1'b1, bits[i]);
  endtask

  // Monitor: compares one queued expectation just after every rising edge.
  initial begin
    bit e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("detected", detected, e);
      end
    end
  end

  initial begin
    bit seq[$];
    bool_wait: begin end
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    din   = 1'b0;

    // Reset held low for 12 ns with random din; detected must stay low.
    #1;
    check("reset_async", detected, 1'b0);
    #6;
    din = 1'($urandom_range(1));
    #5;
    check("reset_hold", detected, 1'b0);
    step(1'b0, 1'($urandom_range(1)));
    step(1'b0, 1'($urandom_range(1)));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Basic match.
    seq = '{1, 1, 1, 0, 0, 0};
    drive_seq(seq);
    // Long run of 1s gives a single pulse.
    seq = '{1, 1, 1, 1, 1, 0, 0};
    drive_seq(seq);
    // Back-to-back matches.
    seq = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
    drive_seq(seq);
    // Near misses never match.
    seq = '{1, 1, 0, 1, 0, 0, 1, 1, 0};
    drive_seq(seq);

    // Short reset pulse between edges after 1,1,1 discards the prefix.
    seq = '{1, 1, 1};
    drive_seq(seq);
    @(negedge clk);
    din = 1'b0;
    #1 reset = 1'b0;
    #1 check("mid_reset_low", detected, 1'b0);
    #2 reset = 1'b1;
    exp_q.push_back(model_edge(1'b0, 1'b0) | model_edge(1'b1, 1'b0));
    step(1'b1, 1'b0);

    // Reset asserted while detected is high drops it immediately.
    seq = '{1, 1, 1, 0};
    drive_seq(seq);
    @(posedge clk);
    #2;
    check("pulse_before_drop", detected, 1'b1);
    reset = 1'b0;
    #1;
    check("pulse_drop", detected, 1'b0);
    hist.delete();
    step(1'b1, 1'b0);

    // Randomized stream, 1s favoured so long runs occur, rare resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 2) ? 1'b0 : 1'b1,
           ($urandom_range(99) < 65) ? 1'b1 : 1'b0);
    end
    step(1'b1, 1'b0);

    // Let the monitor drain the queue, bounded in cycles.
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    check("scoreboard_drained", 1'(exp_q.size() == 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
